// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: start bit, LSB-first payload, optional parity, stop bit.
// Define UART_TX_BACK_TO_BACK_EN to allow a new frame to be accepted during STOP.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_BIT,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  par_en_q;
  logic                  par_q;
  logic                  accept;
  logic                  tx_d;
  logic                  busy_d;

  assign accept = DATA_VALID & ~BUSY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_START;
      S_START:  state_d = S_DATA;
      S_DATA:   if (cnt_q == LAST_CNT) state_d = par_en_q ? S_PARITY : S_STOP;
      S_PARITY: state_d = S_STOP;
      S_STOP: begin
`ifdef UART_TX_BACK_TO_BACK_EN
        state_d = accept ? S_START : S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are derived from the next state and registered, so the line
  // never sees a combinational path from the inputs.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b0;
    case (state_d)
      S_START: begin
        tx_d   = 1'b0;
        busy_d = 1'b1;
      end
      S_DATA: begin
        tx_d   = (state_q == S_DATA) ? shreg_q[1] : shreg_q[0];
        busy_d = 1'b1;
      end
      S_PARITY: begin
        tx_d   = par_q;
        busy_d = 1'b1;
      end
      S_STOP: begin
        tx_d = 1'b1;
`ifdef UART_TX_BACK_TO_BACK_EN
        busy_d = 1'b0;
`else
        busy_d = 1'b1;
`endif
      end
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      TX_OUT <= 1'b1;
      BUSY   <= 1'b0;
    end else begin
      TX_OUT <= tx_d;
      BUSY   <= busy_d;
    end
  end

  // Parity is captured once, leaving START, so the generator may be re-strobed afterwards.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shreg_q  <= '0;
      cnt_q    <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
    end else begin
      if (accept) begin
        shreg_q  <= P_DATA;
        par_en_q <= PAR_EN;
        cnt_q    <= '0;
      end else if (state_q == S_DATA) begin
        shreg_q <= shreg_q >> 1;
        cnt_q   <= cnt_q + CNT_W'(1);
      end
      if (state_q == S_START) begin
        par_q <= PAR_BIT;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed self-checking bench for uart_tx_ctrl; follows UART_TX_BACK_TO_BACK_EN if defined.
module tb_uart_tx_ctrl;

`ifdef UART_TX_BACK_TO_BACK_EN
  localparam logic STOP_BUSY = 1'b0;
`else
  localparam logic STOP_BUSY = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] p_data = 8'h00;
  logic       data_valid = 1'b0;
  logic       par_en = 1'b0;
  logic       par_bit = 1'b0;
  logic       tx_out;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK        (clk),
    .RST        (rst),
    .P_DATA     (p_data),
    .DATA_VALID (data_valid),
    .PAR_EN     (par_en),
    .PAR_BIT    (par_bit),
    .TX_OUT     (tx_out),
    .BUSY       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a byte, let it be accepted, then supply the parity bit and
  // flip PAR_EN to show it no longer matters.
  task automatic send(input logic [7:0] d, input logic pen, input logic pb, input bit hold);
    p_data     = d;
    par_en     = pen;
    data_valid = 1'b1;
    tick();
    data_valid = hold;
    par_bit    = pb;
    par_en     = ~pen;
  endtask

  // Expected vectors are read MSB-first: bit len-1 is the first cycle after accept.
  // mode 1: inject 0xFF request at act; mode 2: toggle PAR_BIT after START; mode 3: drop DATA_VALID at act.
  task automatic check_frame(input string tag, input logic [31:0] tx_v, input logic [31:0] bz_v,
                             input int len, input int mode, input int act);
    for (int i = 0; i < len; i++) begin
      check($sformatf("%s tx[%0d]", tag, i), {31'b0, tx_out}, {31'b0, tx_v[len-1-i]});
      check($sformatf("%s busy[%0d]", tag, i), {31'b0, busy}, {31'b0, bz_v[len-1-i]});
      if (mode == 1 && i == act) begin
        p_data     = 8'hFF;
        data_valid = 1'b1;
      end
      if (mode == 1 && i == act + 1) data_valid = 1'b0;
      if (mode == 2 && i >= 1) par_bit = ~par_bit;
      if (mode == 3 && i == act) data_valid = 1'b0;
      tick();
    end
    check({tag, " idle tx"}, {31'b0, tx_out}, 32'd1);
    check({tag, " idle busy"}, {31'b0, busy}, 32'd0);
  endtask

  function automatic logic [31:0] busy_vec(input int len);
    return ((32'd1 << len) - 32'd2) | {31'b0, STOP_BUSY};
  endfunction

  initial begin
    #1 rst = 1'b1;
    #1;
    check("reset tx", {31'b0, tx_out}, 32'd1);
    check("reset busy", {31'b0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Reset in the middle of a frame, then a clean frame afterwards
    send(8'hA5, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check("midrst tx", {31'b0, tx_out}, 32'd1);
    check("midrst busy", {31'b0, busy}, 32'd0);
    tick();
    check("midrst held tx", {31'b0, tx_out}, 32'd1);
    check("midrst held busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    tick();
    send(8'h00, 1'b0, 1'b0, 1'b0);
    check_frame("post-rst 00", 32'b0000000001, busy_vec(10), 10, 0, 0);

    send(8'hA5, 1'b1, 1'b0, 1'b0);
    check_frame("A5 par", 32'b01010010101, busy_vec(11), 11, 0, 0);

    send(8'h3C, 1'b0, 1'b0, 1'b0);
    check_frame("3C nopar", 32'b0001111001, busy_vec(10), 10, 0, 0);

    send(8'h00, 1'b0, 1'b0, 1'b0);
    check_frame("00 ignore FF", 32'b0000000001, busy_vec(10), 10, 1, 3);

    send(8'h01, 1'b1, 1'b1, 1'b0);
    check_frame("01 par capture", 32'b01000000011, busy_vec(11), 11, 2, 0);

    par_bit = 1'b0;
    tick();
    p_data     = 8'h55;
    par_en     = 1'b1;
    data_valid = 1'b1;
    tick();
    p_data = 8'hAA;
`ifdef UART_TX_BACK_TO_BACK_EN
    check_frame("b2b 55 AA", {10'b0, 11'b01010101001, 11'b00101010101},
                {10'b0, 11'h7FE, 11'h7FE}, 22, 3, 11);
`else
    check_frame("b2b 55 AA", {9'b0, 11'b01010101001, 1'b1, 11'b00101010101},
                {9'b0, 11'h7FF, 1'b0, 11'h7FF}, 23, 3, 12);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit controller: accepts a parallel byte on a valid strobe, serializes it LSB-first, and inserts start, optional parity, and stop bits onto the line output. It sits directly downstream of the parity generator, which is fed the same `P_DATA`/`DATA_VALID` and returns `PAR_BIT` one cycle later. `CLK` is the baud-rate clock, so one bit is emitted per `CLK` cycle.

## Interface
- `DATA_WIDTH`, 8: payload bits per frame; must be ≥ 2.

- `CLK` in 1: baud clock; all state updates on the rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `P_DATA` in `DATA_WIDTH`: payload; sampled only on the accept edge.
- `DATA_VALID` in 1: request to send `P_DATA`.
- `PAR_EN` in 1: 1 = frame includes a parity bit; sampled on the accept edge.
- `PAR_BIT` in 1: parity bit from the parity generator; valid from the cycle after the accept edge.
- `TX_OUT` out 1: serial line; idle level 1.
- `BUSY` out 1: 1 = controller cannot accept `DATA_VALID` this cycle.

## Operation
- Reset (asynchronous, immediate):
  - state = IDLE, `TX_OUT` = 1, `BUSY` = 0.
  - Shift register, bit counter and parity latch cleared.
- Accept edge: rising `CLK` with `DATA_VALID`=1 and `BUSY`=0.
  - `P_DATA` is loaded into the shift register.
  - `PAR_EN` is latched into `par_en_q`; the bit counter is cleared.
  - `DATA_VALID` while `BUSY`=1 is ignored; no state change.
- States:
  - IDLE: `TX_OUT`=1. On accept → START.
  - START: `TX_OUT`=0 for 1 cycle; `PAR_BIT` is captured into `par_q` on the edge leaving START. → DATA.
  - DATA: `TX_OUT` = shift register bit 0; shift right each cycle; counter increments. After `DATA_WIDTH` cycles (counter = `DATA_WIDTH`-1) → PARITY if `par_en_q`, else STOP.
  - PARITY: `TX_OUT` = `par_q` for 1 cycle. → STOP.
  - STOP: `TX_OUT`=1 for 1 cycle. → IDLE, or START (see Configuration).
- `BUSY` = 1 in START, DATA and PARITY. `BUSY` = 1 in STOP unless the macro is defined. `BUSY` = 0 in IDLE.
- Because `PAR_BIT` is captured once, in START, the parity generator may be re-strobed after that cycle without corrupting the frame in flight.
- Counter width: $clog2(`DATA_WIDTH`). No wrap occurs inside a frame; it is cleared on every accept.

## Timing
- `TX_OUT` and `BUSY` are registered outputs with no combinational path from inputs.
- Accept at edge N:
  - `TX_OUT`=0 (start bit) and `BUSY`=1 during cycle N+1.
  - Data bit i during cycle N+2+i.
  - Parity bit during cycle N+2+`DATA_WIDTH` (if enabled).
  - Stop bit during the following cycle.
- Frame length: `DATA_WIDTH`+3 cycles with parity, `DATA_WIDTH`+2 without (11 / 10 at default).
- Without the macro, `BUSY` falls during the cycle after STOP (IDLE). The minimum accept-to-accept spacing is frame length + 1.
- Reset asserted mid-frame: `TX_OUT` returns to 1 and `BUSY` to 0 asynchronously, and the frame is abandoned. The first accept after deassertion starts a full new frame.
- `PAR_EN` changes after the accept edge have no effect on the current frame.

## Configuration
- `UART_TX_BACK_TO_BACK_EN` defined:
  - `BUSY`=0 during STOP.
  - An accept during STOP goes STOP → START directly, giving back-to-back frames with no idle cycle (spacing = frame length).
  - STOP with no `DATA_VALID` → IDLE as usual.
- Not defined: STOP always → IDLE; at least one idle cycle separates consecutive frames.

## Test plan
- Reset mid-frame, then deassert: during reset `TX_OUT`=1 and `BUSY`=0 immediately. Accepting 0x00 with `PAR_EN`=0 after deassertion produces a clean 10-cycle frame: 0,0,0,0,0,0,0,0,0,1.
- `P_DATA`=0xA5, `PAR_EN`=1, `PAR_BIT`=0 (driven from the cycle after accept): `TX_OUT` = 0,1,0,1,0,0,1,0,1,0,1. `BUSY` is high for cycles N+1..N+10 (N+1..N+11 without the macro).
- `P_DATA`=0x3C, `PAR_EN`=0: `TX_OUT` = 0,0,0,1,1,1,1,0,0,1 (10 cycles); no parity slot.
- `DATA_VALID` pulsed with `P_DATA`=0xFF while in DATA of a 0x00 frame: in-flight bits unchanged (all 0); 0xFF is never transmitted.
- `PAR_BIT` toggled on every cycle after START while sending 0x01 with parity: the parity slot shows the value `PAR_BIT` had at the START→DATA edge.
- Back-to-back 0x55 then 0xAA, with `DATA_VALID` held:
  - Macro defined: the second start bit immediately follows the first stop bit; 22 contiguous cycles with parity.
  - Macro undefined: one idle 1 between the stop bit and the second start bit.
